// File: rtl/string_hw_pkg.sv
// Purpose: shared types, constants and character helpers for the string engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package string_hw_pkg;

    typedef enum logic [2:0] {
        OP_STRCMP  = 3'd0,
        OP_TOUPPER = 3'd1,
        OP_TOLOWER = 3'd2,
        OP_REVERSE = 3'd3,
        OP_STRLEN  = 3'd4,
        OP_STRCHR  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] NOT_FOUND = 32'hFFFF_FFFF;

    function automatic logic [7:0] to_upper_c(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'd32 : c;
    endfunction

    function automatic logic [7:0] to_lower_c(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) ? c + 8'd32 : c;
    endfunction

endpackage

// File: rtl/string_lane.sv
// Purpose: per-character compare/search/case-convert unit, one per lane.
// Latency: purely combinational.
// Backpressure: none; the top decides when results are consumed.
module string_lane
    import string_hw_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [7:0] i_ch,
    input  op_t        i_op,
    input  logic       i_valid,
    output logic [7:0] o_byte,
    output logic       o_mismatch,
    output logic       o_gt,
    output logic       o_nul,
    output logic       o_match
);

    // Case conversion for the transform ops; everything else passes the byte through
    always_comb begin
        o_byte = i_a;
        case (i_op)
            OP_TOUPPER: o_byte = to_upper_c(i_a);
            OP_TOLOWER: o_byte = to_lower_c(i_a);
            default:    o_byte = i_a;
        endcase
    end

    // Event flags are qualified by valid so lanes past the length never fire
    assign o_mismatch = i_valid && (i_a != i_b);
    assign o_gt       = i_a > i_b;
    assign o_nul      = i_valid && (i_a == 8'h00);
    assign o_match    = i_valid && (i_a == i_ch);

endmodule

// File: rtl/string_hw_engine.sv
// Purpose: multi-cycle string accelerator (strcmp/toupper/tolower/reverse/strlen/strchr).
// Latency: done 2+N cycles after go is sampled, N = chunks of LANES chars processed.
// Backpressure: level go/done handshake; go must stay high until done, results held in DONE.
module string_hw_engine
    import string_hw_pkg::*;
#(
    parameter  int MAX_CHARS = 32,
    parameter  int LANES     = 4,
    localparam int LEN_W     = $clog2(MAX_CHARS + 1)
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        go,
    input  logic [2:0]                  op,
    input  logic [0:MAX_CHARS-1][7:0]   a,
    input  logic [0:MAX_CHARS-1][7:0]   b,
    input  logic [LEN_W-1:0]            length,
    input  logic [7:0]                  ch,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [0:MAX_CHARS-1][7:0]   result_str,
    output logic [31:0]                 result_val
);

    localparam int              IDX_W   = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHARS);
    localparam logic [LEN_W-1:0] LANES_L = LEN_W'(LANES);

    state_t                      r_state, w_next;
    op_t                         r_op;
    logic [0:MAX_CHARS-1][7:0]   r_a, r_b, r_str;
    logic [7:0]                  r_ch;
    logic [LEN_W-1:0]            r_len, r_base;
    logic [31:0]                 r_val;
    logic                        r_err;

    logic [LANES-1:0]            w_valid, w_mis, w_gt, w_nul, w_match, w_event;
    logic [LEN_W-1:0]            w_idx  [LANES];
    logic [7:0]                  w_lane_a [LANES];
    logic [7:0]                  w_byte [LANES];
    logic                        w_hit, w_hit_mis, w_hit_gt, w_last, w_stop;
    logic [LEN_W-1:0]            w_hit_idx, w_len_clamp;
    logic                        w_op_bad, w_str_op;

    assign w_len_clamp = (length > MAX_LEN) ? MAX_LEN : length;
    assign w_op_bad    = op > 3'd5;
    assign w_str_op    = (r_op == OP_TOUPPER) || (r_op == OP_TOLOWER) || (r_op == OP_REVERSE);
    // r_base is the first index of the current chunk (chunk index j times LANES)
    assign w_last      = (r_base + LANES_L) >= r_len;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IDX_W-1:0] w_src;
        assign w_idx[k]   = r_base + LEN_W'(k);
        assign w_valid[k] = w_idx[k] < r_len;
        // Mirror index for REVERSE; only meaningful for in-range lanes
        assign w_src      = w_valid[k] ? IDX_W'(r_len - LEN_W'(1) - w_idx[k]) : '0;
        assign w_lane_a[k] = (r_op == OP_REVERSE) ? r_a[w_src] : r_a[w_idx[k][IDX_W-1:0]];

        string_lane u_lane (
            .i_a        (w_lane_a[k]),
            .i_b        (r_b[w_idx[k][IDX_W-1:0]]),
            .i_ch       (r_ch),
            .i_op       (r_op),
            .i_valid    (w_valid[k]),
            .o_byte     (w_byte[k]),
            .o_mismatch (w_mis[k]),
            .o_gt       (w_gt[k]),
            .o_nul      (w_nul[k]),
            .o_match    (w_match[k])
        );
    end

    // Select which lane flag terminates the scan for the current op
    always_comb begin
        w_event = '0;
        case (r_op)
            OP_STRCMP: w_event = w_mis | w_nul;
            OP_STRLEN: w_event = w_nul;
            OP_STRCHR: w_event = w_match;
            default:   w_event = '0;
        endcase
    end

    // Lowest-index priority encoder: scan high to low so the lowest lane wins
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_hit_mis = 1'b0;
        w_hit_gt  = 1'b0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (w_event[k]) begin
                w_hit     = 1'b1;
                w_hit_idx = w_idx[k];
                w_hit_mis = w_mis[k];
                w_hit_gt  = w_gt[k];
            end
        end
    end

    assign w_stop = w_hit || w_last;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (go) w_next = LATCH;
            LATCH:   w_next = (w_op_bad || w_len_clamp == '0) ? DONE : RUN;
            RUN:     if (w_stop) w_next = DONE;
            DONE:    if (!go) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, chunk walk and result accumulation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op   <= OP_STRCMP;
            r_a    <= '0;
            r_b    <= '0;
            r_ch   <= '0;
            r_len  <= '0;
            r_base <= '0;
            r_str  <= '0;
            r_val  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_str <= '0;
                        r_val <= '0;
                        r_err <= 1'b0;
                    end
                end
                LATCH: begin
                    r_op   <= op_t'(op);
                    r_a    <= a;
                    r_b    <= b;
                    r_ch   <= ch;
                    r_len  <= w_len_clamp;
                    r_base <= '0;
                    r_err  <= w_op_bad;
                end
                RUN: begin
                    for (int k = 0; k < LANES; k++) begin
                        if (w_valid[k] && w_str_op) r_str[w_idx[k][IDX_W-1:0]] <= w_byte[k];
                    end
                    case (r_op)
                        OP_STRCMP: if (w_hit && w_hit_mis) r_val <= w_hit_gt ? 32'd1 : NOT_FOUND;
                        OP_STRLEN: begin
                            if (w_hit)       r_val <= 32'(w_hit_idx);
                            else if (w_last) r_val <= 32'(r_len);
                        end
                        OP_STRCHR: begin
                            if (w_hit)       r_val <= 32'(w_hit_idx);
                            else if (w_last) r_val <= NOT_FOUND;
                        end
                        default: ;
                    endcase
                    r_base <= r_base + LANES_L;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state == LATCH) || (r_state == RUN);
    assign done       = (r_state == DONE);
    assign error      = r_err;
    assign result_str = r_str;
    assign result_val = r_val;

endmodule
